alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle 64×64→64 (low word) multiplier that acts as the client end of the `if_alu` interface. It computes the product without a wide multiplier by issuing a fixed sequence of 16×16 `ALU_MULW`, `ALU_SHL` and `ALU_ADD` operations to the ALU server. It sits beside the control unit and, while busy, owns the ALU port; requests and results use valid/ready handshakes.

## Interface
- `WIDTH`, default `pkg_reg::REG_WIDTH`: operand/result width. Must equal 64; the design fails elaboration otherwise.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block accepts a request; equals `state==IDLE`.
- `x`, `y`  in  WIDTH  operands; sampled only on acceptance.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer takes the result.
- `p`  out  WIDTH  `(x*y) mod 2^64`.
- `alu`  `if_alu.client`: drives `op`, `a`, `b`; reads `s`. Flags are ignored.

## Operation
- Registers: `state`, `xr`, `yr`, term index `k` (0..9), temp `t`, accumulator `acc`. `p` is driven from `acc`.
- Chunks: `x_i = xr[16i+15:16i]` and `y_j = yr[16j+15:16j]`.
- Terms are processed in fixed order k=0..9 as (i,j): (0,0), (0,1), (1,0), (0,2), (1,1), (2,0), (0,3), (1,2), (2,1), (3,0). These are all pairs with i+j≤3.
- States: IDLE, MUL, SHL, ADD, RESP.
- **IDLE**
  - `op=ALU_NOP`, `a=b=0`.
  - On `req_valid`: latch `xr←x`, `yr←y`, `acc←0`, `k←0`, then go to MUL.
- **MUL**
  - `op=ALU_MULW`, `a={48'b0,x_i}`, `b={48'b0,y_j}`.
  - `t←s`, go to SHL.
- **SHL**
  - `op=ALU_SHL`, `b=t`, `a=16*(i+j)`.
  - `t←s`, go to ADD.
  - SHL is issued even when the shift is 0.
- **ADD**
  - `op=ALU_ADD`, `a=t`, `b=acc`.
  - `acc←s`; the carry-out is discarded, so arithmetic is mod 2^64.
  - If k==9, go to RESP. Otherwise `k←k+1` and go to MUL.
- **RESP**
  - `rsp_valid=1`, `op=ALU_NOP`.
  - `p` is held stable while `rsp_ready=0`.
  - On `rsp_ready`, go to IDLE.
- `req_valid` during MUL..RESP is ignored: `req_ready=0`, and the request is not queued. There is no same-cycle IDLE bypass from RESP.
- `alu.a` and `alu.b` are 0 in every state that drives NOP.

## Timing
- The ALU is combinational to `s`. Each ALU step takes 1 cycle, and its result is registered at the end of that cycle.
- Acceptance happens at edge 0 (cycle 0 is the accept cycle).
  - Cycles 1..30 are 10 terms × (MUL, SHL, ADD).
  - `rsp_valid` rises in cycle 31.
- Minimum request-to-request spacing is 32 cycles, assuming `rsp_ready=1`: accept, 30 ALU cycles, 1 response cycle. `req_ready` returns high the cycle after the response handshake.
- Reset values, asserted asynchronously:
  - `state=IDLE`, `req_ready=1`, `rsp_valid=0`.
  - `acc=p=0`, `t=0`, `k=0`, `xr=yr=0`.
  - `alu.op=ALU_NOP`.
- Reset mid-operation aborts without a response. The first request after deassertion is accepted normally.
- `p` changes only in ADD cycles and at acceptance (cleared). It is not guaranteed meaningful outside RESP.

## Test plan
- **Small operands:** `x=0x1234`, `y=0x5678`.
  - Required: `p=0x0626_0060`, `rsp_valid` first high exactly 31 cycles after acceptance.
  - Cycles 1/2/3 show `op` = MULW/SHL/ADD.
- **All-ones wrap-around:** `x=y=0xFFFF_FFFF_FFFF_FFFF` → `p=0x0000_0000_0000_0001`.
- **Overflow beyond 64 bits:** `x=y=0x0000_0001_0000_0000` → `p=0`.
- **Shifted chunks:** `x=0x0001_0002_0003_0004`, `y=0x10` → `p=0x0010_0020_0030_0040`.
  - In cycle 29 (SHL of term 9), `alu.a=48`.
- **Backpressure:** hold `rsp_ready=0` for 10 cycles in RESP.
  - `p` and `rsp_valid` stay stable; `req_ready=0`.
  - A `req_valid` pulse with new operands is ignored.
  - After `rsp_ready=1`, IDLE follows on the next cycle.
- **Reset mid-operation:** assert `rst` in cycle 15 of an operation.
  - Immediately: `rsp_valid=0`, `req_ready=1`, `op=NOP`, `p=0`.
  - A following request `3×5` yields `p=15` after 31 cycles.

Source files
------------

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Sequential 64x64 -> 64 (low word) multiplier acting as an ALU
//            client. Builds the product from ten 16x16 partial products using
//            a fixed MULW / SHL / ADD sequence issued to an external
//            combinational ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    // request channel
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    // response channel
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] p_o,
    // ALU client port (flags of the server are not used)
    output logic [1:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_s_i
);

    // ALU opcodes understood by the server
    localparam logic [1:0] C_ALU_NOP  = 2'd0;
    localparam logic [1:0] C_ALU_ADD  = 2'd1;
    localparam logic [1:0] C_ALU_SHL  = 2'd2;
    localparam logic [1:0] C_ALU_MULW = 2'd3;

    localparam logic [3:0] C_LAST_TERM = 4'd9;

    // The chunk/term schedule below is hard-wired for four 16-bit chunks
    generate
        if (WIDTH != 64) begin : g_width_check
            $error("alu_mul_seq: WIDTH must be 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_SHL  = 3'd2,
        S_ADD  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xr_q, xr_d;
    logic [WIDTH-1:0] yr_q, yr_d;
    logic [3:0]       k_q, k_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [1:0]       w_ci;     // x chunk index of current term
    logic [1:0]       w_cj;     // y chunk index of current term
    logic [2:0]       w_csum;   // i+j, selects the 16-bit weight of the term
    logic [15:0]      w_xc;
    logic [15:0]      w_yc;
    logic [6:0]       w_shamt;

    // Term schedule: all (i,j) with i+j<=3, ordered by ascending weight
    always_comb begin
        w_ci = 2'd0;
        w_cj = 2'd0;
        case (k_q)
            4'd0:    begin w_ci = 2'd0; w_cj = 2'd0; end
            4'd1:    begin w_ci = 2'd0; w_cj = 2'd1; end
            4'd2:    begin w_ci = 2'd1; w_cj = 2'd0; end
            4'd3:    begin w_ci = 2'd0; w_cj = 2'd2; end
            4'd4:    begin w_ci = 2'd1; w_cj = 2'd1; end
            4'd5:    begin w_ci = 2'd2; w_cj = 2'd0; end
            4'd6:    begin w_ci = 2'd0; w_cj = 2'd3; end
            4'd7:    begin w_ci = 2'd1; w_cj = 2'd2; end
            4'd8:    begin w_ci = 2'd2; w_cj = 2'd1; end
            4'd9:    begin w_ci = 2'd3; w_cj = 2'd0; end
            default: begin w_ci = 2'd0; w_cj = 2'd0; end
        endcase
    end

    assign w_xc    = xr_q[{w_ci, 4'b0000} +: 16];
    assign w_yc    = yr_q[{w_cj, 4'b0000} +: 16];
    assign w_csum  = {1'b0, w_ci} + {1'b0, w_cj};
    assign w_shamt = {w_csum, 4'b0000};

    // Next-state, datapath updates and ALU command decode
    always_comb begin
        state_d  = state_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        k_d      = k_q;
        t_d      = t_q;
        acc_d    = acc_q;
        alu_op_o = C_ALU_NOP;
        alu_a_o  = '0;
        alu_b_o  = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    xr_d    = x_i;
                    yr_d    = y_i;
                    acc_d   = '0;
                    k_d     = 4'd0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                alu_op_o = C_ALU_MULW;
                alu_a_o  = {{(WIDTH-16){1'b0}}, w_xc};
                alu_b_o  = {{(WIDTH-16){1'b0}}, w_yc};
                t_d      = alu_s_i;
                state_d  = S_SHL;
            end
            S_SHL: begin
                // issued even for zero shift to keep the schedule uniform
                alu_op_o = C_ALU_SHL;
                alu_a_o  = {{(WIDTH-7){1'b0}}, w_shamt};
                alu_b_o  = t_q;
                t_d      = alu_s_i;
                state_d  = S_ADD;
            end
            S_ADD: begin
                // carry out of the ALU is dropped: result is mod 2^64
                alu_op_o = C_ALU_ADD;
                alu_a_o  = t_q;
                alu_b_o  = acc_q;
                acc_d    = alu_s_i;
                if (k_q == C_LAST_TERM) begin
                    state_d = S_RESP;
                end else begin
                    k_d     = k_q + 4'd1;
                    state_d = S_MUL;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            k_q     <= 4'd0;
            t_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            k_q     <= k_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign p_o         = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_seq
// Purpose  : Self-checking bench for alu_mul_seq with a behavioural ALU
//            server, directed stimulus and a queue-based response checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    localparam logic [1:0] C_NOP  = 2'd0;
    localparam logic [1:0] C_ADD  = 2'd1;
    localparam logic [1:0] C_SHL  = 2'd2;
    localparam logic [1:0] C_MULW = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] x = '0;
    logic [63:0] y = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] p;
    logic [1:0]  alu_op;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_s;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    typedef struct {
        logic [63:0] p;
        int          e;
        string       nm;
    } exp_t;
    exp_t sbq[$];

    alu_mul_seq #(.WIDTH(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .x_i         (x),
        .y_i         (y),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .p_o         (p),
        .alu_op_o    (alu_op),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_s_i     (alu_s)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU server
    always_comb begin
        alu_s = '0;
        case (alu_op)
            C_ADD:   alu_s = alu_a + alu_b;
            C_SHL:   alu_s = alu_b << alu_a[5:0];
            C_MULW:  alu_s = {32'b0, alu_a[31:0]} * {32'b0, alu_b[31:0]};
            default: alu_s = '0;
        endcase
    end

    initial begin
        forever begin
            @(posedge clk);
            ecnt++;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%h want=0x%h", nm, act, exp);
        end
    endtask

    // Monitor: on each rising rsp_valid pop the oldest expectation
    initial begin
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && !prev_v) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check({e.nm, "_p"}, p, e.p);
                    check({e.nm, "_latency"}, 64'(ecnt - e.e + 1), 64'd31);
                end
            end
            prev_v = (rsp_valid === 1'b1);
        end
    end

    task automatic send(input logic [63:0] xv, input logic [63:0] yv,
                        input logic [63:0] pv, input string nm, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({nm, "_send_timeout"}, 64'd0, 64'd1);
            return;
        end
        x = xv;
        y = yv;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (push) sbq.push_back('{pv, ecnt, nm});
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!(req_ready && sbq.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(req_ready && sbq.size() == 0)) check({nm, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        logic [63:0] held;
        int n;
        int seen;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", {63'b0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_p", p, 64'd0);
        check("rst_op", {62'b0, alu_op}, {62'b0, C_NOP});
        rst = 1'b0;

        // small operands and the first three ALU commands
        send(64'h1234, 64'h5678, 64'h0000_0000_0626_0060, "small", 1'b1);
        @(negedge clk); check("small_op_c1", {62'b0, alu_op}, {62'b0, C_MULW});
        @(negedge clk); check("small_op_c2", {62'b0, alu_op}, {62'b0, C_SHL});
        @(negedge clk); check("small_op_c3", {62'b0, alu_op}, {62'b0, C_ADD});
        wait_idle("small");

        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, "allones", 1'b1);
        wait_idle("allones");

        send(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h0, "overflow", 1'b1);
        wait_idle("overflow");

        send(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF, 64'h0000_0000_FFFE_0001, "ffff_sq", 1'b1);
        wait_idle("ffff_sq");

        // shifted chunks; cycle 29 is the SHL of the last term (weight 3)
        send(64'h0001_0002_0003_0004, 64'h10, 64'h0010_0020_0030_0040, "shifted", 1'b1);
        repeat (29) @(negedge clk);
        check("shifted_c29_op", {62'b0, alu_op}, {62'b0, C_SHL});
        check("shifted_c29_a", alu_a, 64'd48);
        wait_idle("shifted");

        // backpressure in RESP, with an ignored request pulse
        rsp_ready = 1'b0;
        send(64'd7, 64'd9, 64'd63, "bp", 1'b1);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_resp", {63'b0, rsp_valid}, 64'd1);
        held = p;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                x = 64'd11;
                y = 64'd13;
                req_valid = 1'b1;
            end
            if (i == 4) req_valid = 1'b0;
            @(negedge clk);
            check("bp_p_stable", p, held);
            check("bp_rsp_valid", {63'b0, rsp_valid}, 64'd1);
            check("bp_req_ready", {63'b0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_req_ready", {63'b0, req_ready}, 64'd1);
        check("bp_idle_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) seen++;
        end
        check("bp_ignored_req", 64'(seen), 64'd0);

        // reset in the middle of an operation
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h0, "abort", 1'b0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("mid_rst_req_ready", {63'b0, req_ready}, 64'd1);
        check("mid_rst_op", {62'b0, alu_op}, {62'b0, C_NOP});
        check("mid_rst_p", p, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send(64'd3, 64'd5, 64'd15, "after_rst", 1'b1);
        wait_idle("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
